// File: rtl/commit_checker.sv
// commit_checker: observes the register-file commit stream and compares each
// commit against a loadable expected-value table with a per-register check
// mask. It produces sticky PASS / FAIL / TIMEOUT verdicts, and it keeps a
// record of the first mismatch.
module commit_checker #(
  parameter int unsigned NUM_REGS       = 8,
  parameter int unsigned ADDR_W         = 3,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 600,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned FIRST_ONLY     = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                exp_we,
  input  logic [ADDR_W-1:0]   exp_addr,
  input  logic [DATA_W-1:0]   exp_data,
  input  logic                exp_chk,
  input  logic                commit_we,
  input  logic [ADDR_W-1:0]   commit_waddr,
  input  logic [DATA_W-1:0]   commit_wdata,
  output logic                busy,
  output logic                pass,
  output logic                fail,
  output logic                timeout,
  output logic [NUM_REGS-1:0] seen_mask,
  output logic [CNT_W-1:0]    commit_cnt,
  output logic [CNT_W-1:0]    cycle_cnt,
  output logic [ADDR_W-1:0]   fail_addr,
  output logic [DATA_W-1:0]   fail_got,
  output logic [DATA_W-1:0]   fail_exp
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RUN     = 3'd1;
  localparam logic [2:0] S_PASS    = 3'd2;
  localparam logic [2:0] S_FAIL    = 3'd3;
  localparam logic [2:0] S_TIMEOUT = 3'd4;

  localparam logic [CNT_W:0] TMO_LIM = (CNT_W+1)'(TIMEOUT_CYCLES);

  logic [2:0]          state_q, state_d;
  logic [DATA_W-1:0]   exp_tbl_q [NUM_REGS];
  logic [DATA_W-1:0]   exp_tbl_d [NUM_REGS];
  logic [NUM_REGS-1:0] chk_q, chk_d;
  logic [NUM_REGS-1:0] seen_q, seen_d;
  logic [CNT_W-1:0]    commit_cnt_q, commit_cnt_d;
  logic [CNT_W-1:0]    cycle_cnt_q, cycle_cnt_d;
  logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0]   fail_got_q, fail_got_d;
  logic [DATA_W-1:0]   fail_exp_q, fail_exp_d;
  logic                busy_q, pass_q, fail_q, timeout_q;

  logic [NUM_REGS-1:0] hit;
  logic [NUM_REGS-1:0] set_bits;
  logic [DATA_W-1:0]   sel_exp;
  logic                do_check;
  logic                mismatch;
  logic                covered;
  logic                tmo;
  logic [CNT_W:0]      cyc_inc;

  // Decode the committed register and evaluate the check for this cycle.
  // Addresses at or above NUM_REGS leave hit all-zero, so they only count.
  always_comb begin
    hit     = '0;
    sel_exp = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      if (commit_waddr == ADDR_W'(r)) begin
        hit[r]  = commit_we;
        sel_exp = exp_tbl_q[r];
      end
    end
    do_check = (state_q == S_RUN) && ((hit & chk_q) != '0) &&
               !((FIRST_ONLY != 0) && ((hit & seen_q) != '0));
    mismatch = do_check && (commit_wdata != sel_exp);
    set_bits = (do_check && (commit_wdata == sel_exp)) ? hit : '0;
    covered  = (((seen_q | set_bits) & chk_q) == chk_q);
    cyc_inc  = {1'b0, cycle_cnt_q} + (CNT_W+1)'(1);
    tmo      = (cyc_inc >= TMO_LIM);
  end

  // Next-state logic: RUN tracks commits and verdicts; all other states accept
  // table writes and (re)arm on start.
  always_comb begin
    state_d      = state_q;
    exp_tbl_d    = exp_tbl_q;
    chk_d        = chk_q;
    seen_d       = seen_q;
    commit_cnt_d = commit_cnt_q;
    cycle_cnt_d  = cycle_cnt_q;
    fail_addr_d  = fail_addr_q;
    fail_got_d   = fail_got_q;
    fail_exp_d   = fail_exp_q;
    if (state_q == S_RUN) begin
      if (commit_we && (commit_cnt_q != '1)) commit_cnt_d = commit_cnt_q + CNT_W'(1);
      if (cycle_cnt_q != '1) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
      seen_d = seen_q | set_bits;
      if (mismatch) begin
        state_d     = S_FAIL;
        fail_addr_d = commit_waddr;
        fail_got_d  = commit_wdata;
        fail_exp_d  = sel_exp;
      end else if (covered) begin
        state_d = S_PASS;
      end else if (tmo) begin
        state_d = S_TIMEOUT;
      end
    end else begin
      if (exp_we) begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
          if (exp_addr == ADDR_W'(r)) begin
            exp_tbl_d[r] = exp_data;
            chk_d[r]     = exp_chk;
          end
        end
      end
      if (start) begin
        seen_d       = '0;
        commit_cnt_d = '0;
        cycle_cnt_d  = '0;
        fail_addr_d  = '0;
        fail_got_d   = '0;
        fail_exp_d   = '0;
        // Nothing to verify: skip RUN entirely.
        state_d      = (chk_d == '0) ? S_PASS : S_RUN;
      end
    end
  end

  // State, table and record registers; flags are registered from the next state
  // so each verdict and busy change on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      for (int unsigned r = 0; r < NUM_REGS; r++) exp_tbl_q[r] <= '0;
      chk_q        <= '0;
      seen_q       <= '0;
      commit_cnt_q <= '0;
      cycle_cnt_q  <= '0;
      fail_addr_q  <= '0;
      fail_got_q   <= '0;
      fail_exp_q   <= '0;
      busy_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      exp_tbl_q    <= exp_tbl_d;
      chk_q        <= chk_d;
      seen_q       <= seen_d;
      commit_cnt_q <= commit_cnt_d;
      cycle_cnt_q  <= cycle_cnt_d;
      fail_addr_q  <= fail_addr_d;
      fail_got_q   <= fail_got_d;
      fail_exp_q   <= fail_exp_d;
      busy_q       <= (state_d == S_RUN);
      pass_q       <= (state_d == S_PASS);
      fail_q       <= (state_d == S_FAIL);
      timeout_q    <= (state_d == S_TIMEOUT);
    end
  end

  assign busy       = busy_q;
  assign pass       = pass_q;
  assign fail       = fail_q;
  assign timeout    = timeout_q;
  assign seen_mask  = seen_q;
  assign commit_cnt = commit_cnt_q;
  assign cycle_cnt  = cycle_cnt_q;
  assign fail_addr  = fail_addr_q;
  assign fail_got   = fail_got_q;
  assign fail_exp   = fail_exp_q;

endmodule

// File: tb/tb_commit_checker.sv
// Directed bench for commit_checker: a FIRST_ONLY=0 and a FIRST_ONLY=1 instance
// share stimulus, both with a 20-cycle timeout.
module tb_commit_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, exp_we, exp_chk, commit_we;
  logic [2:0]  exp_addr, commit_waddr;
  logic [15:0] exp_data, commit_wdata;

  logic        busy, pass, fail, timeout;
  logic [7:0]  seen_mask;
  logic [15:0] commit_cnt, cycle_cnt, fail_got, fail_exp;
  logic [2:0]  fail_addr;

  logic        fo_busy, fo_pass, fo_fail, fo_timeout;
  logic [7:0]  fo_seen_mask;
  logic [15:0] fo_commit_cnt, fo_cycle_cnt, fo_fail_got, fo_fail_exp;
  logic [2:0]  fo_fail_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  commit_checker #(.TIMEOUT_CYCLES(20), .FIRST_ONLY(0)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data), .exp_chk(exp_chk),
    .commit_we(commit_we), .commit_waddr(commit_waddr), .commit_wdata(commit_wdata),
    .busy(busy), .pass(pass), .fail(fail), .timeout(timeout),
    .seen_mask(seen_mask), .commit_cnt(commit_cnt), .cycle_cnt(cycle_cnt),
    .fail_addr(fail_addr), .fail_got(fail_got), .fail_exp(fail_exp)
  );

  commit_checker #(.TIMEOUT_CYCLES(20), .FIRST_ONLY(1)) u_fo (
    .clk(clk), .rst(rst), .start(start),
    .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data), .exp_chk(exp_chk),
    .commit_we(commit_we), .commit_waddr(commit_waddr), .commit_wdata(commit_wdata),
    .busy(fo_busy), .pass(fo_pass), .fail(fo_fail), .timeout(fo_timeout),
    .seen_mask(fo_seen_mask), .commit_cnt(fo_commit_cnt), .cycle_cnt(fo_cycle_cnt),
    .fail_addr(fo_fail_addr), .fail_got(fo_fail_got), .fail_exp(fo_fail_exp)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Each stimulus task starts and ends on a falling edge.
  task automatic wr(input logic [2:0] a, input logic [15:0] d, input logic c);
    exp_we = 1'b1; exp_addr = a; exp_data = d; exp_chk = c;
    @(negedge clk);
    exp_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic cmt(input logic [2:0] a, input logic [15:0] d);
    commit_we = 1'b1; commit_waddr = a; commit_wdata = d;
    @(negedge clk);
    commit_we = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; exp_we = 1'b0; exp_chk = 1'b0; commit_we = 1'b0;
    exp_addr = '0; commit_waddr = '0; exp_data = '0; commit_wdata = '0;
    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_flags", 32'({pass, fail, timeout}), 0);
    chk("rst_seen", 32'(seen_mask), 0);
    chk("rst_ccnt", 32'(commit_cnt), 0);
    chk("rst_cyc", 32'(cycle_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Full pass: R1=5 R2=0 R3=5 R4=10, mask 0x1E
    wr(3'd1, 16'd5, 1'b1);
    wr(3'd2, 16'd0, 1'b1);
    wr(3'd3, 16'd5, 1'b1);
    wr(3'd4, 16'd10, 1'b1);
    pulse_start();
    chk("p_busy_rise", 32'(busy), 1);
    chk("p_cyc0", 32'(cycle_cnt), 0);
    cmt(3'd1, 16'd5);
    cmt(3'd2, 16'd0);
    cmt(3'd3, 16'd5);
    chk("p_not_yet", 32'(pass), 0);
    cmt(3'd4, 16'd10);
    chk("p_pass", 32'(pass), 1);
    chk("p_busy_fall", 32'(busy), 0);
    chk("p_seen", 32'(seen_mask), 32'h1E);
    chk("p_ccnt", 32'(commit_cnt), 4);
    chk("p_cyc", 32'(cycle_cnt), 4);
    chk("p_fo_pass", 32'(fo_pass), 1);

    // Mismatch on R3, later commit ignored
    pulse_start();
    chk("f_pass_clr", 32'(pass), 0);
    cmt(3'd3, 16'd6);
    chk("f_fail", 32'(fail), 1);
    chk("f_busy", 32'(busy), 0);
    chk("f_addr", 32'(fail_addr), 3);
    chk("f_got", 32'(fail_got), 6);
    chk("f_exp", 32'(fail_exp), 5);
    cmt(3'd4, 16'd10);
    chk("f_sticky", 32'({pass, fail, timeout}), 32'b010);
    chk("f_frz_seen", 32'(seen_mask), 0);
    chk("f_frz_ccnt", 32'(commit_cnt), 1);
    chk("f_frz_cyc", 32'(cycle_cnt), 1);
    chk("f_frz_got", 32'(fail_got), 6);
    chk("f_rec_clr_pre", 32'(fo_fail), 1);

    // Timeout with only R1 committed: 20 cycles after busy rose
    pulse_start();
    chk("t_fail_clr", 32'(fail), 0);
    chk("t_rec_clr", 32'(fail_got), 0);
    cmt(3'd1, 16'd5);
    idle(18);
    chk("t_not_yet", 32'(timeout), 0);
    chk("t_cyc19", 32'(cycle_cnt), 19);
    idle(1);
    chk("t_timeout", 32'(timeout), 1);
    chk("t_cyc20", 32'(cycle_cnt), 20);
    chk("t_busy", 32'(busy), 0);
    chk("t_ccnt", 32'(commit_cnt), 1);
    chk("t_seen", 32'(seen_mask), 32'h02);

    // FIRST_ONLY contrast: R1=5 then R1=7
    pulse_start();
    cmt(3'd1, 16'd5);
    cmt(3'd1, 16'd7);
    chk("fo0_fail", 32'(fail), 1);
    chk("fo0_got", 32'(fail_got), 7);
    chk("fo0_addr", 32'(fail_addr), 1);
    chk("fo0_exp", 32'(fail_exp), 5);
    chk("fo1_nofail", 32'(fo_fail), 0);
    chk("fo1_busy", 32'(fo_busy), 1);
    chk("fo1_seen", 32'(fo_seen_mask), 32'h02);
    chk("fo1_ccnt", 32'(fo_commit_cnt), 2);

    // Last match coincides with timeout edge: PASS wins
    pulse_start();
    cmt(3'd1, 16'd5);
    cmt(3'd2, 16'd0);
    cmt(3'd3, 16'd5);
    idle(16);
    chk("pt_busy19", 32'(busy), 1);
    cmt(3'd4, 16'd10);
    chk("pt_flags", 32'({pass, fail, timeout}), 32'b100);
    chk("pt_cyc", 32'(cycle_cnt), 20);

    // Mismatch coincides with timeout edge: FAIL wins
    pulse_start();
    cmt(3'd1, 16'd5);
    cmt(3'd2, 16'd0);
    cmt(3'd3, 16'd5);
    idle(16);
    cmt(3'd4, 16'd11);
    chk("ft_flags", 32'({pass, fail, timeout}), 32'b010);
    chk("ft_got", 32'(fail_got), 32'hB);

    // Asynchronous reset mid-RUN
    pulse_start();
    cmt(3'd1, 16'd5);
    chk("r_pre_busy", 32'(busy), 1);
    #1 rst = 1'b1;
    #1;
    chk("r_busy", 32'(busy), 0);
    chk("r_seen", 32'(seen_mask), 0);
    chk("r_ccnt", 32'(commit_cnt), 0);
    chk("r_cyc", 32'(cycle_cnt), 0);
    chk("r_fo_busy", 32'(fo_busy), 0);
    @(negedge clk);
    rst = 1'b0;

    // Table cleared by reset: empty mask passes on the start edge
    pulse_start();
    chk("e_pass", 32'(pass), 1);
    chk("e_busy", 32'(busy), 0);

    // R0 only; a table write during RUN must be ignored
    wr(3'd0, 16'h1234, 1'b1);
    pulse_start();
    chk("z_busy", 32'(busy), 1);
    wr(3'd0, 16'h9999, 1'b1);
    cmt(3'd0, 16'h1234);
    chk("z_pass", 32'(pass), 1);
    chk("z_fail", 32'(fail), 0);
    chk("z_seen", 32'(seen_mask), 32'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
